// File: rtl/validator_pkg.sv
// Shared types and constants for the validator engine: FSM states, lane pipeline
// depth and the squared-distance result width.
package validator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned LANE_DEPTH = 2;

    function automatic int unsigned dist_w(input int unsigned n);
        return 2 * n + 3;
    endfunction

endpackage

// File: rtl/validator_engine_if.sv
// Candidate beat stream: LANES packed points per beat with a valid/ready handshake.
interface validator_engine_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 8
) ();

    logic [N*LANES-1:0] cp_x;
    logic [N*LANES-1:0] cp_y;
    logic [N*LANES-1:0] cp_z;
    logic               cp_valid;
    logic               cp_ready;

    modport master (output cp_x, cp_y, cp_z, cp_valid, input cp_ready);
    modport slave  (input cp_x, cp_y, cp_z, cp_valid, output cp_ready);

endinterface

// File: rtl/sq_dist_lane.sv
// One candidate lane: stage 1 forms the signed deltas, stage 2 the squared distance
// and the strict radius compare.
module sq_dist_lane
    import validator_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   valid,
    input  logic signed [N-1:0]    cp_x,
    input  logic signed [N-1:0]    cp_y,
    input  logic signed [N-1:0]    cp_z,
    input  logic signed [N-1:0]    point_x,
    input  logic signed [N-1:0]    point_y,
    input  logic signed [N-1:0]    point_z,
    input  logic [dist_w(N)-1:0]   radius_sq,
    output logic                   hit
);

    localparam int unsigned DW = dist_w(N);

    logic [LANE_DEPTH-1:0] vld;
    logic signed [N:0]     dx, dy, dz;
    logic signed [DW-1:0]  ex, ey, ez;
    logic [DW-1:0]         dsq;
    logic                  hit_q;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld <= '0;
        end else begin
            vld <= {vld[LANE_DEPTH-2:0], valid};
        end
    end

    always_ff @(posedge clock) begin
        dx    <= {cp_x[N-1], cp_x} - {point_x[N-1], point_x};
        dy    <= {cp_y[N-1], cp_y} - {point_y[N-1], point_y};
        dz    <= {cp_z[N-1], cp_z} - {point_z[N-1], point_z};
        hit_q <= dsq < radius_sq;
    end

    // Deltas are widened to the result width before squaring so no product truncates.
    always_comb begin
        ex  = DW'(dx);
        ey  = DW'(dy);
        ez  = DW'(dz);
        dsq = $unsigned(ex * ex + ey * ey + ez * ez);
    end

    assign hit = vld[LANE_DEPTH-1] & hit_q;

endmodule

// File: rtl/validator_engine.sv
// Radius-neighbour validator: scans a candidate stream and classifies one point as
// inlier/outlier. Optional macro VALIDATOR_EARLY_EXIT_EN stops once the threshold is met.
module validator_engine
    import validator_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [N-1:0]   point_x,
    input  logic signed [N-1:0]   point_y,
    input  logic signed [N-1:0]   point_z,
    input  logic [2*N-1:0]        point_cloud_size,
    input  logic [CNT_W-1:0]      neighbor_threshold,
    input  logic [dist_w(N)-1:0]  radius_sq,
    validator_engine_if.slave     cp,
    output logic                  busy,
    output logic                  done,
    output logic                  inlier,
    output logic                  outlier,
    output logic [CNT_W-1:0]      neighbor_count
);

    localparam int unsigned PW = $clog2(LANES + 1);
    localparam int unsigned SW = CNT_W + PW;

    state_t                 state, state_nxt;
    logic signed [N-1:0]    px, py, pz;
    logic [2*N-1:0]         size_q, issued;
    logic [CNT_W-1:0]       thr_q, count, count_nxt;
    logic [dist_w(N)-1:0]   rsq_q;
    logic                   drain_cnt;
    logic                   accept, flush;
    logic [LANES-1:0]       live, hits;
    logic [PW-1:0]          pop;
    logic [SW-1:0]          count_sum;

    assign accept = cp.cp_valid && cp.cp_ready;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_comb begin
        state_nxt   = state;
        cp.cp_ready = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                cp.cp_ready = (issued < size_q);
                if (issued >= size_q) state_nxt = DRAIN;
            end
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef VALIDATOR_EARLY_EXIT_EN
        if ((state == RUN || state == DRAIN) && count_nxt >= thr_q) state_nxt = DONE;
`endif
    end

`ifdef VALIDATOR_EARLY_EXIT_EN
    assign flush = (state != DONE) && (state_nxt == DONE);
`else
    assign flush = 1'b0;
`endif

    // Liveness is decided at acceptance so the partial final beat never counts dead lanes.
    always_comb begin
        live = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            live[k] = ({1'b0, issued} + (2*N+1)'(k)) < {1'b0, size_q};
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            pop = pop + PW'(hits[k]);
        end
        count_sum = SW'(count) + SW'(pop);
        count_nxt = (|count_sum[SW-1:CNT_W]) ? '1 : count_sum[CNT_W-1:0];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sq_dist_lane #(.N(N)) u_lane (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .valid     (accept && live[k]),
            .cp_x      (cp.cp_x[k*N +: N]),
            .cp_y      (cp.cp_y[k*N +: N]),
            .cp_z      (cp.cp_z[k*N +: N]),
            .point_x   (px),
            .point_y   (py),
            .point_z   (pz),
            .radius_sq (rsq_q),
            .hit       (hits[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            issued         <= '0;
            count          <= '0;
            drain_cnt      <= 1'b0;
            inlier         <= 1'b0;
            outlier        <= 1'b0;
            neighbor_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN);
            if (state == IDLE && start) begin
                px             <= point_x;
                py             <= point_y;
                pz             <= point_z;
                size_q         <= point_cloud_size;
                thr_q          <= neighbor_threshold;
                rsq_q          <= radius_sq;
                issued         <= '0;
                count          <= '0;
                inlier         <= 1'b0;
                outlier        <= 1'b0;
                neighbor_count <= '0;
            end
            if (accept) issued <= issued + (2*N)'(LANES);
            if (state == RUN || state == DRAIN) count <= count_nxt;
            // Result is latched from the count as it stands on entry to DONE.
            if (state != DONE && state_nxt == DONE) begin
                inlier         <= (count_nxt >= thr_q);
                outlier        <= (count_nxt < thr_q);
                neighbor_count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_validator_engine.sv
// Self-checking bench for validator_engine: directed table, randomized scans against a
// distance model, reset abort, counter saturation and (with VALIDATOR_EARLY_EXIT_EN) early exit.
module tb_validator_engine;

    localparam int N     = 16;
    localparam int LANES = 8;
    localparam int CNT_W = 16;
    localparam int DW    = 2 * N + 3;
    localparam int MAXC  = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 start, busy, done, inlier, outlier;
    logic signed [N-1:0]  px, py, pz;
    logic [2*N-1:0]       size;
    logic [CNT_W-1:0]     thr, ncount;
    logic [DW-1:0]        rsq;
    validator_engine_if #(.N(N), .LANES(LANES)) cpi ();

    validator_engine #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset(rst), .start(start),
        .point_x(px), .point_y(py), .point_z(pz),
        .point_cloud_size(size), .neighbor_threshold(thr), .radius_sq(rsq),
        .cp(cpi), .busy(busy), .done(done), .inlier(inlier), .outlier(outlier),
        .neighbor_count(ncount)
    );

    logic                 s_start, s_busy, s_done, s_inlier, s_outlier;
    logic [2*N-1:0]       s_size;
    logic [3:0]           s_thr, s_ncount;
    validator_engine_if #(.N(N), .LANES(LANES)) cps ();

    validator_engine #(.N(N), .LANES(LANES), .CNT_W(4)) dut_s (
        .clock(clk), .reset(rst), .start(s_start),
        .point_x(16'sd0), .point_y(16'sd0), .point_z(16'sd0),
        .point_cloud_size(s_size), .neighbor_threshold(s_thr), .radius_sq(35'd2),
        .cp(cps), .busy(s_busy), .done(s_done), .inlier(s_inlier), .outlier(s_outlier),
        .neighbor_count(s_ncount)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cx[MAXC], cy[MAXC], cz[MAXC];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: count candidates strictly inside the radius, saturating at 2^cw-1.
    function automatic longint ref_count(input int p_x, input int p_y, input int p_z,
                                         input int unsigned sz, input longint r, input int cw);
        longint c = 0;
        for (int i = 0; i < int'(sz); i++) begin
            longint dx = longint'(cx[i] - p_x);
            longint dy = longint'(cy[i] - p_y);
            longint dz = longint'(cz[i] - p_z);
            if (dx * dx + dy * dy + dz * dz < r) c++;
        end
        if (c > (longint'(1) << cw) - 1) c = (longint'(1) << cw) - 1;
        return c;
    endfunction

    task automatic fill(input int vx, input int vy, input int vz);
        for (int i = 0; i < MAXC; i++) begin
            cx[i] = vx; cy[i] = vy; cz[i] = vz;
        end
    endtask

    task automatic run_scan(input string tag, input int p_x, input int p_y, input int p_z,
                            input int unsigned sz, input int th, input longint r,
                            input longint exp_cnt, input bit exp_in, input bit bubbles,
                            input bit poke, output int cyc_done, output int beats);
        int  nb;
        bit  got;
        bit  chk_cnt;
        nb = (int'(sz) + LANES - 1) / LANES;
        got = 0; beats = 0; cyc_done = -1;
        chk_cnt = 1;
`ifdef VALIDATOR_EARLY_EXIT_EN
        if (exp_in) chk_cnt = 0;
`endif
        @(posedge clk); #1;
        px = 16'(p_x); py = 16'(p_y); pz = 16'(p_z);
        size = sz; thr = 16'(th); rsq = 35'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; size = $urandom; thr = 16'($urandom);
        for (int cyc = 0; cyc < nb * 4 + 40 && !got; cyc++) begin
            start = poke && (cyc == 2);
            if (start) size = 32'd0;
            if (beats < nb && (!bubbles || $urandom_range(0, 3) != 0)) begin
                cpi.cp_valid = 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    cpi.cp_x[k*N +: N] = 16'(cx[beats*LANES+k]);
                    cpi.cp_y[k*N +: N] = 16'(cy[beats*LANES+k]);
                    cpi.cp_z[k*N +: N] = 16'(cz[beats*LANES+k]);
                end
            end else begin
                cpi.cp_valid = 1'b0;
                cpi.cp_x = {$urandom, $urandom, $urandom, $urandom};
                cpi.cp_y = {$urandom, $urandom, $urandom, $urandom};
                cpi.cp_z = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (cpi.cp_valid && cpi.cp_ready) beats++;
            if (done) begin
                got = 1;
                cyc_done = cyc;
                check({tag, "_inlier"}, inlier, exp_in);
                check({tag, "_outlier"}, outlier, !exp_in);
                if (chk_cnt) check({tag, "_count"}, ncount, exp_cnt);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        cpi.cp_valid = 1'b0;
        if (!got) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            @(negedge clk);
            check({tag, "_done_pulse_len"}, done, 0);
            check({tag, "_idle_after"}, busy, 0);
            check({tag, "_inlier_held"}, inlier, exp_in);
        end
    endtask

    typedef struct {
        string       name;
        int          px, py, pz, cx, cy, cz;
        int unsigned size;
        int          thr;
        longint      rsq;
        longint      exp_cnt;
        bit          exp_in;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cd, nbts;
        int unsigned rsz;
        int rpx, rpy, rpz, rth;
        longint rr, rexp;
        bit seen;

        rst = 1'b1; start = 1'b0; px = '0; py = '0; pz = '0;
        size = '0; thr = '0; rsq = '0;
        cpi.cp_valid = 1'b0; cpi.cp_x = '0; cpi.cp_y = '0; cpi.cp_z = '0;
        s_start = 1'b0; s_size = '0; s_thr = '0;
        cps.cp_valid = 1'b0; cps.cp_x = '0; cps.cp_y = '0; cps.cp_z = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_inlier", inlier, 0);
        check("reset_outlier", outlier, 0);
        check("reset_count", ncount, 0);
        check("reset_cp_ready", cpi.cp_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs[0] = '{"hit16",      0, 0, 0, 3, 4, 0, 16, 10, 26, 16, 1'b1};
        vecs[1] = '{"strict25",   0, 0, 0, 3, 4, 0, 16, 10, 25, 0, 1'b0};
        vecs[2] = '{"partial13",  0, 0, 0, 3, 4, 0, 13, 13, 26, 13, 1'b1};
        vecs[3] = '{"empty_thr0", 0, 0, 0, 3, 4, 0, 0, 0, 26, 0, 1'b1};
        vecs[4] = '{"empty_thr1", 0, 0, 0, 3, 4, 0, 0, 1, 26, 0, 1'b0};
        vecs[5] = '{"thr0_miss",  0, 0, 0, 3, 4, 0, 5, 0, 25, 0, 1'b1};
        vecs[6] = '{"negative",  -5, -5, -5, -2, -1, -5, 20, 21, 26, 20, 1'b0};
        vecs[7] = '{"extreme_hit", 32767, 32767, 32767, -32768, -32768, -32768,
                    9, 9, 64'd34359738367, 9, 1'b1};
        vecs[8] = '{"extreme_edge", 32767, 32767, 32767, -32768, -32768, -32768,
                    9, 1, 64'd12884508675, 0, 1'b0};
        vecs[9] = '{"bubbles24",  0, 0, 0, 3, 4, 0, 24, 24, 26, 24, 1'b1};

        for (int i = 0; i < 10; i++) begin
            fill(vecs[i].cx, vecs[i].cy, vecs[i].cz);
            run_scan(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].pz, vecs[i].size,
                     vecs[i].thr, vecs[i].rsq, vecs[i].exp_cnt, vecs[i].exp_in,
                     (i % 2) == 1, 1'b0, cd, nbts);
        end

        for (int it = 0; it < 24; it++) begin
            rsz = $urandom_range(0, 40);
            rpx = int'($urandom_range(0, 15)) - 8;
            rpy = int'($urandom_range(0, 15)) - 8;
            rpz = int'($urandom_range(0, 15)) - 8;
            rr  = longint'($urandom_range(0, 200));
            rth = int'($urandom_range(0, rsz + 2));
            for (int j = 0; j < 64; j++) begin
                cx[j] = int'($urandom_range(0, 15)) - 8;
                cy[j] = int'($urandom_range(0, 15)) - 8;
                cz[j] = int'($urandom_range(0, 15)) - 8;
            end
            rexp = ref_count(rpx, rpy, rpz, rsz, rr, CNT_W);
            run_scan($sformatf("rand%0d", it), rpx, rpy, rpz, rsz, rth, rr, rexp,
                     rexp >= longint'(rth), 1'b1, 1'b1, cd, nbts);
        end

        // Reset in the third RUN cycle aborts silently.
        @(posedge clk); #1;
        px = '0; py = '0; pz = '0; size = 64; thr = 1; rsq = 26; start = 1'b1;
        cpi.cp_x = {LANES{16'd3}}; cpi.cp_y = {LANES{16'd4}}; cpi.cp_z = '0;
        @(posedge clk); #1;
        start = 1'b0; cpi.cp_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; cpi.cp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_inlier", inlier, 0);
        check("abort_outlier", outlier, 0);
        check("abort_count", ncount, 0);
        check("abort_cp_ready", cpi.cp_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        fill(3, 4, 0);
        run_scan("post_abort_empty", 0, 0, 0, 0, 0, 26, 0, 1'b1, 1'b0, 1'b0, cd, nbts);

        // Narrow counter saturates; a start pulse mid-RUN must not restart the scan.
        @(posedge clk); #1;
        s_start = 1'b1; s_size = 32; s_thr = 4'd15;
        cps.cp_x = {LANES{16'd1}}; cps.cp_y = '0; cps.cp_z = '0;
        @(posedge clk); #1;
        s_start = 1'b0; s_size = '0;
        seen = 0; nbts = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            s_start = (c == 1);
            if (s_start) s_thr = 4'd0;
            cps.cp_valid = (nbts < 4);
            @(negedge clk);
            if (cps.cp_valid && cps.cp_ready) nbts++;
            if (s_done) begin
                seen = 1;
                check("sat_count", s_ncount, 15);
                check("sat_inlier", s_inlier, 1);
                check("sat_outlier", s_outlier, 0);
            end
            @(posedge clk); #1;
        end
        s_start = 1'b0; cps.cp_valid = 1'b0;
        if (!seen) check("sat_done_timeout", 0, 1);

`ifdef VALIDATOR_EARLY_EXIT_EN
        fill(3, 4, 0);
        run_scan("early_exit", 0, 0, 0, 800, 30, 26, 0, 1'b1, 1'b0, 1'b0, cd, nbts);
        check("early_exit_latency_ok", (cd >= 0 && cd <= 7), 1);
        check("early_exit_beats_ok", (nbts <= 6), 1);
        @(negedge clk);
        check("early_exit_cp_ready", cpi.cp_ready, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
